// File: rtl/cpu_ri_multicycle_if.sv
// Core-side bundle of the multi-cycle CPU: instruction-memory port plus
// the registered status/writeback outputs observed by the SoC.
interface cpu_ri_multicycle_if #(
    parameter int DATA_W = 32,
    parameter int IM_AW  = 6
);
    logic [IM_AW-1:0]  inst_addr;
    logic [31:0]       inst;
    logic              ZF;
    logic              OF;
    logic              Write_Reg;
    logic [DATA_W-1:0] W_Data;
    logic              halted;
    logic [1:0]        state;

    // CPU core side
    modport master (
        output inst_addr,
        output ZF,
        output OF,
        output Write_Reg,
        output W_Data,
        output halted,
        output state,
        input  inst
    );

    // Instruction ROM / observer side
    modport slave (
        input  inst_addr,
        input  ZF,
        input  OF,
        input  Write_Reg,
        input  W_Data,
        input  halted,
        input  state,
        output inst
    );
endinterface

// File: rtl/cpu_ri_multicycle.sv
// Multi-cycle R/I-type ALU CPU core. Every instruction walks
// FETCH -> DECODE -> EXEC -> WB; an illegal encoding parks the core in HALT
// until reset. Register file reads happen only in DECODE, writes only in WB.
module cpu_ri_multicycle #(
    parameter int DATA_W = 32,
    parameter int IM_AW  = 6
) (
    input logic               clk,
    input logic               Reset,
    cpu_ri_multicycle_if.master bus
);

    localparam int SH_W = $clog2(DATA_W);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_SLTU = 3'b110;
    localparam logic [2:0] OP_SLLV = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t state_q, state_d;

    logic [IM_AW-1:0]  pc_q;
    logic [31:0]       ir_q;
    logic [DATA_W-1:0] a_q, b_q, f_q;
    logic [2:0]        alu_op_q;
    logic [4:0]        dest_q;
    logic              zf_q, of_q;
    logic [DATA_W-1:0] rf [32];

    // Instruction fields
    logic [5:0]  opcode, func;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;

    assign opcode = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign func   = ir_q[5:0];
    assign imm16  = ir_q[15:0];

    logic [DATA_W-1:0] imm_sext, imm_zext, imm_lui;

    assign imm_sext = {{(DATA_W-16){imm16[15]}}, imm16};
    assign imm_zext = {{(DATA_W-16){1'b0}}, imm16};
    assign imm_lui  = {imm_sext[DATA_W-17:0], 16'h0000};

    // Decoder outputs
    logic              dec_legal;
    logic [2:0]        dec_op;
    logic [4:0]        dec_dest;
    logic              dec_use_imm;
    logic [DATA_W-1:0] dec_imm;
    logic              dec_zero_a;

    // Instruction decode: legality, ALU op, B-operand source and destination
    always_comb begin
        dec_legal   = 1'b0;
        dec_op      = OP_AND;
        dec_dest    = rd;
        dec_use_imm = 1'b0;
        dec_imm     = imm_sext;
        dec_zero_a  = 1'b0;
        case (opcode)
            6'b000000: begin
                dec_legal = 1'b1;
                case (func)
                    6'b100100: dec_op = OP_AND;
                    6'b100101: dec_op = OP_OR;
                    6'b100110: dec_op = OP_XOR;
                    6'b100111: dec_op = OP_NOR;
                    6'b100000: dec_op = OP_ADD;
                    6'b100010: dec_op = OP_SUB;
                    6'b101011: dec_op = OP_SLTU;
                    6'b000100: dec_op = OP_SLLV;
                    default:   dec_legal = 1'b0;
                endcase
            end
            6'b001000: begin
                dec_legal = 1'b1; dec_op = OP_ADD;  dec_dest = rt;
                dec_use_imm = 1'b1; dec_imm = imm_sext;
            end
            6'b001011: begin
                dec_legal = 1'b1; dec_op = OP_SLTU; dec_dest = rt;
                dec_use_imm = 1'b1; dec_imm = imm_sext;
            end
            6'b001100: begin
                dec_legal = 1'b1; dec_op = OP_AND;  dec_dest = rt;
                dec_use_imm = 1'b1; dec_imm = imm_zext;
            end
            6'b001101: begin
                dec_legal = 1'b1; dec_op = OP_OR;   dec_dest = rt;
                dec_use_imm = 1'b1; dec_imm = imm_zext;
            end
            6'b001110: begin
                dec_legal = 1'b1; dec_op = OP_XOR;  dec_dest = rt;
                dec_use_imm = 1'b1; dec_imm = imm_zext;
            end
            6'b001111: begin
                dec_legal = 1'b1; dec_op = OP_OR;   dec_dest = rt;
                dec_use_imm = 1'b1; dec_imm = imm_lui; dec_zero_a = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // ALU on the latched operands, with signed overflow for ADD/SUB only
    logic [DATA_W-1:0] alu_res, sum, diff;
    logic              alu_of;

    assign sum  = a_q + b_q;
    assign diff = a_q - b_q;

    always_comb begin
        alu_res = '0;
        alu_of  = 1'b0;
        case (alu_op_q)
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_NOR:  alu_res = ~(a_q | b_q);
            OP_ADD: begin
                alu_res = sum;
                alu_of  = (a_q[DATA_W-1] == b_q[DATA_W-1]) &&
                          (sum[DATA_W-1] != a_q[DATA_W-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_of  = (a_q[DATA_W-1] != b_q[DATA_W-1]) &&
                          (diff[DATA_W-1] != a_q[DATA_W-1]);
            end
            OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (a_q < b_q)};
            OP_SLLV: alu_res = b_q << a_q[SH_W-1:0];
            default: alu_res = '0;
        endcase
    end

    // Next-state logic for the fetch/decode/execute/writeback sequence
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = dec_legal ? S_EXEC : S_HALT;
            S_EXEC:   state_d = S_WB;
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // State register and per-stage datapath registers
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            f_q      <= '0;
            alu_op_q <= OP_AND;
            dest_q   <= '0;
            zf_q     <= 1'b0;
            of_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_FETCH: begin
                    ir_q <= bus.inst;
                    pc_q <= pc_q + IM_AW'(1);
                end
                S_DECODE: begin
                    if (dec_legal) begin
                        a_q      <= dec_zero_a ? '0 : rf[rs];
                        b_q      <= dec_use_imm ? dec_imm : rf[rt];
                        alu_op_q <= dec_op;
                        dest_q   <= dec_dest;
                    end
                end
                S_EXEC: begin
                    f_q  <= alu_res;
                    zf_q <= (alu_res == '0);
                    of_q <= alu_of;
                end
                default: begin
                end
            endcase
        end
    end

    // Register file write in WB; r0 is never written so it always reads zero
    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (state_q == S_WB && dest_q != 5'd0) begin
            rf[dest_q] <= f_q;
        end
    end

    assign bus.inst_addr = pc_q;
    assign bus.ZF        = zf_q;
    assign bus.OF        = of_q;
    assign bus.W_Data    = f_q;
    assign bus.Write_Reg = (state_q == S_WB);
    assign bus.halted    = (state_q == S_HALT);
    assign bus.state     = (state_q == S_HALT) ? 2'b11 : state_q[1:0];

endmodule

// File: tb/tb_cpu_ri_multicycle.sv
// Directed bench for cpu_ri_multicycle: a table of instructions with
// hand-computed writeback results, then halt, reset-in-WB and PC-wrap sequences.
module tb_cpu_ri_multicycle;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   total_checks;
    int   passed_checks;

    cpu_ri_multicycle_if #(.DATA_W(32), .IM_AW(6)) bus_a ();
    cpu_ri_multicycle_if #(.DATA_W(32), .IM_AW(2)) bus_b ();

    logic [31:0] rom_a [64];
    logic [31:0] rom_b [4];

    assign bus_a.inst = rom_a[bus_a.inst_addr];
    assign bus_b.inst = rom_b[bus_b.inst_addr];

    cpu_ri_multicycle #(.DATA_W(32), .IM_AW(6)) dut (
        .clk   (clk),
        .Reset (rst_a),
        .bus   (bus_a.master)
    );

    cpu_ri_multicycle #(.DATA_W(32), .IM_AW(2)) dut_wrap (
        .clk   (clk),
        .Reset (rst_b),
        .bus   (bus_b.master)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] data;
        logic        zf;
        logic        of_f;
    } vec_t;

    vec_t vecs [24];

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total_checks++;
        if (actual === expected) begin
            passed_checks++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst_a_v, input logic rst_b_v, input int cycles);
        rst_a = rst_a_v;
        rst_b = rst_b_v;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic checkResetA(input string tag);
        checkOutput({tag, "_state"},     64'(bus_a.state),     64'd0);
        checkOutput({tag, "_inst_addr"}, 64'(bus_a.inst_addr), 64'd0);
        checkOutput({tag, "_halted"},    64'(bus_a.halted),    64'd0);
        checkOutput({tag, "_write_reg"}, 64'(bus_a.Write_Reg), 64'd0);
        checkOutput({tag, "_w_data"},    64'(bus_a.W_Data),    64'd0);
        checkOutput({tag, "_zf"},        64'(bus_a.ZF),        64'd0);
        checkOutput({tag, "_of"},        64'(bus_a.OF),        64'd0);
    endtask

    // Main directed sequence
    initial begin
        logic wr_seen;
        total_checks  = 0;
        passed_checks = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;

        vecs[0]  = '{32'h20010005, 32'h00000005, 1'b0, 1'b0}; // addi r1,r0,5
        vecs[1]  = '{32'h2002FFFD, 32'hFFFFFFFD, 1'b0, 1'b0}; // addi r2,r0,-3
        vecs[2]  = '{32'h00221820, 32'h00000002, 1'b0, 1'b0}; // add r3,r1,r2
        vecs[3]  = '{32'h3C047FFF, 32'h7FFF0000, 1'b0, 1'b0}; // lui r4,0x7fff
        vecs[4]  = '{32'h00842820, 32'hFFFE0000, 1'b0, 1'b1}; // add r5,r4,r4
        vecs[5]  = '{32'h00213022, 32'h00000000, 1'b1, 1'b0}; // sub r6,r1,r1
        vecs[6]  = '{32'h20000009, 32'h00000009, 1'b0, 1'b0}; // addi r0,r0,9
        vecs[7]  = '{32'h00001820, 32'h00000000, 1'b1, 1'b0}; // add r3,r0,r0
        vecs[8]  = '{32'h00223824, 32'h00000005, 1'b0, 1'b0}; // and r7,r1,r2
        vecs[9]  = '{32'h00223825, 32'hFFFFFFFD, 1'b0, 1'b0}; // or
        vecs[10] = '{32'h00223826, 32'hFFFFFFF8, 1'b0, 1'b0}; // xor
        vecs[11] = '{32'h00223827, 32'h00000002, 1'b0, 1'b0}; // nor
        vecs[12] = '{32'h0022382B, 32'h00000001, 1'b0, 1'b0}; // sltu r7,r1,r2
        vecs[13] = '{32'h0041382B, 32'h00000000, 1'b1, 1'b0}; // sltu r7,r2,r1
        vecs[14] = '{32'h00243804, 32'hFFE00000, 1'b0, 1'b0}; // sllv r7,r4,r1
        vecs[15] = '{32'h00223822, 32'h00000008, 1'b0, 1'b0}; // sub r7,r1,r2
        vecs[16] = '{32'h00A43822, 32'h7FFF0000, 1'b0, 1'b1}; // sub r7,r5,r4
        vecs[17] = '{32'h2C28FFFF, 32'h00000001, 1'b0, 1'b0}; // sltiu r8,r1,-1
        vecs[18] = '{32'h3048FFFF, 32'h0000FFFD, 1'b0, 1'b0}; // andi r8,r2,0xffff
        vecs[19] = '{32'h34088000, 32'h00008000, 1'b0, 1'b0}; // ori r8,r0,0x8000
        vecs[20] = '{32'h3828FFFF, 32'h0000FFFA, 1'b0, 1'b0}; // xori r8,r1,0xffff
        vecs[21] = '{32'h3C298000, 32'h80000000, 1'b0, 1'b0}; // lui r9,0x8000 (rs=r1)
        vecs[22] = '{32'h212AFFFF, 32'h7FFFFFFF, 1'b0, 1'b1}; // addi r10,r9,-1
        vecs[23] = '{32'h00605825, 32'h00000000, 1'b1, 1'b0}; // or r11,r3,r0

        for (int i = 0; i < 64; i++) rom_a[i] = 32'hFC000000;
        for (int i = 0; i < 24; i++) rom_a[i] = vecs[i].inst;
        for (int i = 0; i < 4; i++)  rom_b[i] = 32'h20210001;

        applyStimulus(1'b1, 1'b1, 2);
        checkResetA("reset");

        // Table-driven program: one instruction per four cycles
        applyStimulus(1'b0, 1'b1, 0);
        for (int i = 0; i < 24; i++) begin
            checkOutput($sformatf("fetch_state[%0d]", i), 64'(bus_a.state), 64'd0);
            checkOutput($sformatf("fetch_addr[%0d]", i), 64'(bus_a.inst_addr), 64'(i));
            if (i > 0) begin
                checkOutput($sformatf("hold_w_data[%0d]", i), 64'(bus_a.W_Data),
                            64'(vecs[i-1].data));
            end
            @(negedge clk);
            checkOutput($sformatf("decode_state[%0d]", i), 64'(bus_a.state), 64'd1);
            @(negedge clk);
            checkOutput($sformatf("exec_wr[%0d]", i), 64'(bus_a.Write_Reg), 64'd0);
            @(negedge clk);
            checkOutput($sformatf("wb_state[%0d]", i), 64'(bus_a.state), 64'd3);
            checkOutput($sformatf("wb_write_reg[%0d]", i), 64'(bus_a.Write_Reg), 64'd1);
            checkOutput($sformatf("wb_data[%0d]", i), 64'(bus_a.W_Data), 64'(vecs[i].data));
            checkOutput($sformatf("wb_zf[%0d]", i), 64'(bus_a.ZF), 64'(vecs[i].zf));
            checkOutput($sformatf("wb_of[%0d]", i), 64'(bus_a.OF), 64'(vecs[i].of_f));
            @(negedge clk);
        end

        // Illegal word at address 24: halt, PC and flags hold
        checkOutput("illegal_fetch_addr", 64'(bus_a.inst_addr), 64'd24);
        @(negedge clk);
        @(negedge clk);
        checkOutput("halt_halted", 64'(bus_a.halted), 64'd1);
        checkOutput("halt_state", 64'(bus_a.state), 64'd3);
        checkOutput("halt_pc", 64'(bus_a.inst_addr), 64'd25);
        checkOutput("halt_w_data", 64'(bus_a.W_Data), 64'd0);
        checkOutput("halt_zf", 64'(bus_a.ZF), 64'd1);
        wr_seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus_a.Write_Reg !== 1'b0 || bus_a.halted !== 1'b1) wr_seen = 1'b1;
        end
        checkOutput("halt_no_write_20", 64'(wr_seen), 64'd0);
        checkOutput("halt_pc_held", 64'(bus_a.inst_addr), 64'd25);

        // Illegal R-type func at word 0
        applyStimulus(1'b1, 1'b1, 1);
        checkResetA("reset_from_halt");
        rom_a[0] = 32'h00221821;
        applyStimulus(1'b0, 1'b1, 2);
        checkOutput("illegal0_halted", 64'(bus_a.halted), 64'd1);
        checkOutput("illegal0_pc", 64'(bus_a.inst_addr), 64'd1);
        checkOutput("illegal0_w_data", 64'(bus_a.W_Data), 64'd0);
        checkOutput("illegal0_zf", 64'(bus_a.ZF), 64'd0);
        repeat (20) @(negedge clk);
        checkOutput("illegal0_pc_held", 64'(bus_a.inst_addr), 64'd1);
        checkOutput("illegal0_wr", 64'(bus_a.Write_Reg), 64'd0);

        // Reset asserted during WB of addi r1,r0,5 drops the write
        applyStimulus(1'b1, 1'b1, 1);
        rom_a[0] = 32'h20010005;
        applyStimulus(1'b0, 1'b1, 3);
        checkOutput("midwb_write_reg", 64'(bus_a.Write_Reg), 64'd1);
        checkOutput("midwb_w_data", 64'(bus_a.W_Data), 64'd5);
        applyStimulus(1'b1, 1'b1, 1);
        checkResetA("midwb_reset");
        rom_a[0] = 32'h00201025; // or r2,r1,r0 reads back r1
        applyStimulus(1'b0, 1'b1, 0);
        checkOutput("midwb_refetch_addr", 64'(bus_a.inst_addr), 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("midwb_r1_data", 64'(bus_a.W_Data), 64'd0);
        checkOutput("midwb_r1_zf", 64'(bus_a.ZF), 64'd1);

        // PC wrap with a 4-word ROM: eight increments of r1
        applyStimulus(1'b1, 1'b0, 0);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("wrap_addr[%0d]", i), 64'(bus_b.inst_addr), 64'(i % 4));
            repeat (3) @(negedge clk);
            checkOutput($sformatf("wrap_data[%0d]", i), 64'(bus_b.W_Data), 64'(i + 1));
            @(negedge clk);
        end
        checkOutput("wrap_addr_final", 64'(bus_b.inst_addr), 64'd0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/cpu_ri_multicycle.md
# cpu_ri_multicycle

Multi-cycle successor to the single-cycle R-type CPU: executes R-type and I-type ALU instructions over a fixed 4-state FSM (fetch, decode, execute, writeback) with registered datapath stages. Datapath width and instruction-memory address width are parametrised. Adds I-type immediates, a program counter with an external instruction-memory port, and halt-on-illegal. Flags and writeback are registered. The block is the CPU core of the lab SoC, in front of a combinational instruction ROM.

## Interface
- `DATA_W`, 32: datapath/register width. Legal values are 32 and 64.
- `IM_AW`, 6: instruction-memory word-address width. The PC wraps modulo 2^IM_AW.
- `clk`  in  1  the single clock. All state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high. Has priority over every other update.
- `inst_addr`  out  IM_AW  word address of the instruction; equals PC.
- `inst`  in  32  instruction word. Combinational ROM data, sampled at the end of FETCH.
- `ZF`  out  1  registered zero flag of the last executed instruction.
- `OF`  out  1  registered signed-overflow flag of the last executed instruction.
- `Write_Reg`  out  1  high during the WB cycle of a legal instruction.
- `W_Data`  out  DATA_W  registered ALU result (F register).
- `halted`  out  1  high while the FSM is in HALT.
- `state`  out  2  debug state code.

## Operation
- State codes: FETCH=00, DECODE=01, EXEC=10, WB=11, plus HALT, which reports as `state`=11 with `halted`=1.
- FETCH: IR<=inst; PC<=PC+1, wrapping at 2^IM_AW-1 -> 0. Next state is DECODE.
- DECODE:
  - Illegal opcode/func -> HALT. No register write, no flag change.
  - Otherwise, latch A<=RF[rs] and latch B<=RF[rt] (R-type) or B<=ext(imm16) (I-type).
  - Latch ALU_OP and the destination: rd for R-type, rt for I-type.
- EXEC: F<=ALU(A,B); ZF<=(F==0); OF is set only for ADD/SUB signed overflow at DATA_W, else 0. Next state is WB.
- WB: RF[dest]<=F; Write_Reg=1. Writes to r0 are discarded, so r0 always reads 0. Next state is FETCH.
- HALT: stays in HALT until Reset. PC, RF, F and flags hold.
- ALU_OP: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB, 110 SLTU (unsigned less-than, result 0/1), 111 SLLV (B << A[4:0], or A[5:0] when DATA_W=64).
- R-type (OP=000000), func -> ALU_OP:
  - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR.
  - 100000 ADD, 100010 SUB, 101011 SLTU, 000100 SLLV.
- I-type opcodes:
  - 001000 ADDI (sign-extend), 001011 SLTIU (sign-extend, unsigned compare).
  - 001100 ANDI, 001101 ORI, 001110 XORI (zero-extend).
  - 001111 LUI: B={sign-ext to DATA_W of imm16,16'b0}, op OR with A forced to 0.
- Every other OP/func is illegal.
- RF: 32 x DATA_W. Read is asynchronous, sampled only in DECODE. Write is on the rising edge in WB.

## Timing
- CPI=4. For an instruction fetched in cycle n: decode n+1, exec n+2, write n+3.
- The result is readable by the next instruction's DECODE at n+5. There are no hazards and no forwarding is needed.
- `inst` must be valid during every FETCH cycle. It is ignored in all other states.
- Reset values: PC=0, state=FETCH, halted=0, ZF=0, OF=0, W_Data=0, Write_Reg=0, IR=0, all RF=0.
- Reset asserted mid-instruction, including during WB: the pending write is dropped, and fetch of address 0 begins the cycle after Reset deasserts.
- W_Data/ZF/OF change only at the end of EXEC and hold through WB and FETCH.

## Test plan
- Load/add: ROM 0x20010005 (addi r1,r0,5), 0x2002FFFD (addi r2,r0,-3), 0x00221820 (add r3,r1,r2) -> at cycle 11 Write_Reg=1, W_Data=2, ZF=0, OF=0; RF[3]=2.
- Overflow/zero: 0x3C047FFF (lui r4) -> W_Data=0x7FFF0000. Then 0x00842820 (add r5,r4,r4) -> W_Data=0xFFFE0000, OF=1. Then 0x00213022 (sub r6,r1,r1) -> W_Data=0, ZF=1, OF=0.
- r0 protection: 0x20000009 (addi r0,r0,9), then 0x00001820 (add r3,r0,r0) -> W_Data=0; RF[0] stays 0.
- Illegal: ROM word 0xFC000000 -> halted=1 from the cycle after DECODE; PC=1 held; Write_Reg stays 0 for 20 cycles; Reset -> PC=0, halted=0.
- PC wrap: IM_AW=2, all words 0x20210001 (addi r1,r1,1) -> inst_addr sequence 0,1,2,3,0; after 8 instructions RF[1]=8.
- Reset mid-WB: assert Reset in the WB cycle of addi r1,r0,5 -> RF[1]=0; next FETCH at inst_addr=0; all outputs at reset values.
